// File: rtl/wave_buffer_scheduler.sv
// Double-buffer swap controller for the waveform sample RAM: arms capture into one half
// while the display reads the other, and swaps halves during blanking on selected vsync edges.
module wave_buffer_scheduler #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             wave_display_idle,
  input  logic             capture_done,
  input  logic             freeze,
  input  logic [DIV_W-1:0] frame_div,
  output logic             capture_arm,
  output logic             read_index,
  output logic             write_half,
  output logic             swap,
  output logic [7:0]       missed
);

  // Handshake: capture_done is a one-cycle pulse that is only honoured while capture_arm
  // is high; a falling capture_arm without capture_done means the capture was aborted.

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_SWAP  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             vs_d;
  logic             pending;
  logic [DIV_W-1:0] div_cnt;
  logic             rise;
  logic             elig;
  logic             go;

  assign rise = vsync & ~vs_d;
  assign elig = rise & (div_cnt == frame_div);
  assign go   = (state == ST_READY) & ~freeze & wave_display_idle & (pending | elig);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!freeze) state_nxt = ST_ARMED;
      ST_ARMED: if (capture_done) state_nxt = ST_READY;
      ST_READY: if (go) state_nxt = ST_SWAP;
      ST_SWAP:  state_nxt = freeze ? ST_IDLE : ST_ARMED;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // vs_d resets high so a vsync already high at reset release is not seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      vs_d        <= 1'b1;
      div_cnt     <= '0;
      pending     <= 1'b0;
      missed      <= 8'd0;
      capture_arm <= 1'b0;
      swap        <= 1'b0;
      read_index  <= 1'b0;
      write_half  <= 1'b1;
    end else begin
      state       <= state_nxt;
      vs_d        <= vsync;
      capture_arm <= (state_nxt == ST_ARMED);
      swap        <= (state_nxt == ST_SWAP);

      // A divider setting lowered below the count wraps on the next edge without eligibility.
      if (rise) div_cnt <= (div_cnt >= frame_div) ? '0 : div_cnt + DIV_ONE;

      // Pending limits a late swap to the frame opened by the eligible edge.
      if (go)        pending <= 1'b0;
      else if (elig) pending <= 1'b1;
      else if (rise) pending <= 1'b0;

      if (elig && (state == ST_ARMED) && !capture_done && (missed != 8'hFF))
        missed <= missed + 8'd1;

      if (go) begin
        read_index <= ~read_index;
        write_half <= read_index;
      end
    end
  end

endmodule

// File: tb/tb_wave_buffer_scheduler.sv
// Bench for wave_buffer_scheduler: vector table, directed corner sequences and a random
// run checked every cycle against a frame-level behavioural model.
module tb_wave_buffer_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       wave_display_idle;
  logic       capture_done;
  logic       freeze;
  logic [3:0] frame_div;
  logic       capture_arm;
  logic       read_index;
  logic       write_half;
  logic       swap;
  logic [7:0] missed;

  int checks   = 0;
  int failures = 0;

  wave_buffer_scheduler #(.DIV_W(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .vsync             (vsync),
    .wave_display_idle (wave_display_idle),
    .capture_done      (capture_done),
    .freeze            (freeze),
    .frame_div         (frame_div),
    .capture_arm       (capture_arm),
    .read_index        (read_index),
    .write_half        (write_half),
    .swap              (swap),
    .missed            (missed)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_IDLE, M_CAPTURING, M_FULL, M_SWAPPING} phase_t;
  phase_t m_phase;
  int     m_rises;        // edges seen since the last eligible one
  bit     m_prev_vs;
  bit     m_pend;
  bit     m_ri;
  int     m_missed;

  function automatic void model_reset();
    m_phase   = M_IDLE;
    m_rises   = 0;
    m_prev_vs = 1'b1;
    m_pend    = 1'b0;
    m_ri      = 1'b0;
    m_missed  = 0;
  endfunction

  function automatic void model_step();
    bit r, e, do_swap;
    r = vsync && !m_prev_vs;
    e = r && (m_rises == int'(frame_div));
    do_swap = (m_phase == M_FULL) && !freeze && wave_display_idle && (m_pend || e);
    if (e && m_phase == M_CAPTURING && !capture_done && m_missed < 255) m_missed++;
    if (r) m_rises = (m_rises >= int'(frame_div)) ? 0 : m_rises + 1;
    if (do_swap) m_pend = 1'b0;
    else if (e)  m_pend = 1'b1;
    else if (r)  m_pend = 1'b0;
    case (m_phase)
      M_IDLE:      if (!freeze) m_phase = M_CAPTURING;
      M_CAPTURING: if (capture_done) m_phase = M_FULL;
      M_FULL:      if (do_swap) begin m_phase = M_SWAPPING; m_ri = !m_ri; end
      default:     m_phase = freeze ? M_IDLE : M_CAPTURING;
    endcase
    m_prev_vs = vsync;
  endfunction

  function automatic logic [11:0] model_vec();
    return {(m_phase == M_CAPTURING), m_ri, !m_ri, (m_phase == M_SWAPPING), 8'(m_missed)};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {capture_arm, read_index, write_half, swap, missed};
  endfunction

  function automatic string fmt(logic [11:0] v);
    return $sformatf("arm=%b ri=%b wh=%b swap=%b missed=%0d", v[11], v[10], v[9], v[8], v[7:0]);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_vec(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got {%s} expected {%s}", name, $time, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive inputs, advance the model on the rising edge, compare.
  task automatic step(input logic vs, input logic cd, input logic fr, input logic idl);
    vsync = vs; capture_done = cd; freeze = fr; wave_display_idle = idl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_vec("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    capture_done = 1'b0; freeze = 1'b0; wave_display_idle = 1'b1;
    model_reset();
    @(negedge clk);
    check_vec("reset_state", dut_vec(), {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       vs, cd, fr, idl;
    logic       arm, ri, sw;
    logic [7:0] mis;
  } vec_t;

  vec_t tbl[19];
  bit   any_swap;

  initial begin
    reset = 1'b1; vsync = 1'b0; capture_done = 1'b0; freeze = 1'b0;
    wave_display_idle = 1'b1; frame_div = 4'd0;

    // vs cd fr idl | arm ri sw missed
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};

    @(negedge clk);

    // Vector table: basic swap, late swap via pending, freeze and coincident events.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].vs, tbl[i].cd, tbl[i].fr, tbl[i].idl);
      check_vec($sformatf("table[%0d]", i), dut_vec(),
                {tbl[i].arm, tbl[i].ri, ~tbl[i].ri, tbl[i].sw, tbl[i].mis});
    end

    // Decimation: frame_div=2, swaps only on rises 3, 6, 9.
    frame_div = 4'd2;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check_val($sformatf("decim_swap_rise%0d", k), int'(swap), (k % 3 == 0) ? 1 : 0);
    end
    check_val("decim_missed", int'(missed), 0);

    // Missed frames: capture never finishes across 300 eligible rises.
    frame_div = 4'd0;
    do_reset();
    any_swap = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1); any_swap |= swap;
      step(1'b0, 1'b0, 1'b0, 1'b1); any_swap |= swap;
    end
    check_val("missed_saturated", int'(missed), 255);
    check_val("missed_no_swap", int'(any_swap), 0);
    check_val("missed_read_index", int'(read_index), 0);

    // Freeze across 5 eligible rises, released mid-frame.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    any_swap = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1); any_swap |= swap;
      step(1'b0, 1'b0, 1'b1, 1'b1); any_swap |= swap;
    end
    check_val("freeze_no_swap", int'(any_swap), 0);
    check_val("freeze_arm_low", int'(capture_arm), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("freeze_release_swap", int'(swap), 1);
    check_val("freeze_release_ri", int'(read_index), 1);

    // Freeze released after a non-eligible rise: wait for the next eligible one.
    frame_div = 4'd1;
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
    end
    any_swap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1); any_swap |= swap;
    end
    check_val("unfreeze_noelig_no_swap", int'(any_swap), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("unfreeze_next_elig_swap", int'(swap), 1);

    // Blanking gate: eligible rise while displaying, idle arrives 40 cycles later.
    frame_div = 4'd0;
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    any_swap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0); any_swap |= swap;
    end
    check_val("blank_wait_no_swap", int'(any_swap), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("blank_late_swap", int'(swap), 1);

    // capture_done coincident with the eligible rise.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_val("coinc_no_swap_yet", int'(swap), 0);
    check_val("coinc_missed", int'(missed), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("coinc_swap_next", int'(swap), 1);
    check_val("coinc_missed_after", int'(missed), 0);

    // Asynchronous reset while armed with non-zero state, released with vsync high.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_vec("pre_async_reset", dut_vec(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd1});
    vsync = 1'b1;
    #2 reset = 1'b1;
    #1 check_vec("async_reset_immediate", dut_vec(), {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    any_swap = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1); any_swap |= swap;
    end
    check_val("vsync_high_release_no_rise", int'(any_swap), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("first_real_rise_swap", int'(swap), 1);

    // Random traffic against the model, including divider changes on the fly.
    for (int seg = 0; seg < 4; seg++) begin
      logic vs_r, fr_r;
      frame_div = 4'($urandom_range(0, 3));
      vs_r = 1'b0; fr_r = 1'b0;
      vsync = 1'b0;
      do_reset();
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 5) == 0) vs_r = ~vs_r;
        if ($urandom_range(0, 60) == 0) fr_r = ~fr_r;
        if ($urandom_range(0, 299) == 0) frame_div = 4'($urandom_range(0, 3));
        step(vs_r, ($urandom_range(0, 6) == 0), fr_r, ($urandom_range(0, 3) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_buffer_scheduler.md
# wave_buffer_scheduler

Frame-level controller for the double-buffered waveform sample RAM. It arms waveform capture into one RAM half while the display reads the other. It swaps the halves only inside display blanking on a selected vsync edge. It also supports freeze (hold the displayed trace), frame decimation and a missed-frame counter. It sits between the waveform capture logic, the display timing generator and the waveform renderer, and owns the `read_index` that both the capture logic and the renderer consume.

## Interface
Parameters:
- `DIV_W`, default 4: width of the frame-divider setting and counter.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `vsync`  in  1  vertical sync level from the display timing generator; active-high.
- `wave_display_idle`  in  1  high when the renderer is not reading the sample RAM (blanking).
- `capture_done`  in  1  one-cycle pulse: capture has finished writing the half given by `write_half`.
- `freeze`  in  1  level; while high, no swap occurs and capture is not re-armed.
- `frame_div`  in  DIV_W  a swap is allowed at most once per `frame_div`+1 vsync rising edges.
- `capture_arm`  out  1  registered; high exactly while the state is ARMED.
- `read_index`  out  1  RAM half read by the display.
- `write_half`  out  1  RAM half written by capture; always equals ~`read_index`.
- `swap`  out  1  one-cycle pulse in the cycle following a `read_index` toggle.
- `missed`  out  8  saturating count of eligible vsync edges lost because capture was still running.

## Operation
- **vsync edge detection:** `vs_d` registers `vsync`. `rise` = `vsync` & ~`vs_d`.
- **Divider:**
  - `div_cnt` counts `rise` events from 0 to `frame_div`, then wraps to 0. It runs in every state.
  - `elig` = `rise` & (`div_cnt` == `frame_div`). With `frame_div`=0, every rise is eligible.
  - If `frame_div` changes below the current `div_cnt`, the counter wraps to 0 on the next rise; that rise is not eligible.
- **Pending flag:**
  - Set on `elig`.
  - Cleared on any non-eligible `rise`, and on entry to SWAP.
  - Effect: a swap can happen only in the frame that began with the eligible edge.
- **Swap condition:** `go` = state==READY & ~`freeze` & `wave_display_idle` & (`pending` | `elig`).
- **States:**
  - IDLE: `capture_arm`=0. Goes to ARMED when `freeze`=0; stays in IDLE while `freeze`=1.
  - ARMED: `capture_arm`=1. Goes to READY on `capture_done`. Any other `capture_done` (in other states) is ignored.
  - READY: `capture_arm`=0; the buffer is full. Goes to SWAP on `go`, otherwise holds. `freeze` holds READY indefinitely.
  - SWAP: lasts one cycle. `capture_arm`=0 and `swap`=1. Next state is ARMED if `freeze`=0, IDLE if `freeze`=1.
- **Toggle:** `read_index` and `write_half` toggle on the clock edge that enters SWAP. `capture_arm` is low on both sides of the toggle, so the write half never changes while capture is armed.
- **missed:** increments by 1 on `elig` while the state is ARMED and `capture_done`=0. It saturates at 255 and clears only on reset.
- **Simultaneous events:**
  - `capture_done` and `elig` in the same ARMED cycle: go to READY, set `pending`, do not increment `missed`. The swap can then occur on the next cycle if `wave_display_idle`=1.
  - `elig` and `freeze` in READY: set `pending` but do not swap. If `freeze` drops before the next `rise`, the swap still occurs in the same frame.
- **Reset values:** state IDLE, `read_index`=0, `write_half`=1, `capture_arm`=0, `swap`=0, `missed`=0, `div_cnt`=0, `pending`=0, `vs_d`=1. Setting `vs_d`=1 suppresses a false edge if `vsync` is high at reset release.
- **Reset mid-operation:** all of the above return to their reset values immediately (asynchronous). The capture logic must treat the falling edge of `capture_arm` as an abort.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `vsync` first sampled high at clock edge n:
  - `div_cnt`, `pending` and `missed` update at edge n.
  - If `go` is true, the state becomes SWAP at edge n: `read_index` toggles and `swap`=1 during cycle n..n+1.
  - `capture_arm` rises at edge n+1.
- `capture_done` at edge m in ARMED: `capture_arm` is low from edge m.
- Minimum capture-done to swap latency: 0 cycles from READY entry, i.e. `go` is evaluated in the first READY cycle.
- Throughput: at most one swap per (`frame_div`+1) frames.

## Test plan
- **Basic swap:** reset; `freeze`=0, `frame_div`=0, `wave_display_idle`=1. Then `capture_done` pulse, then a `vsync` rise. Required: `capture_arm` 0→1 one cycle after reset release; `read_index` 0→1 at the rise edge; `swap`=1 for exactly one cycle; `capture_arm` high again the following cycle.
- **Decimation:** `frame_div`=2, capture always done early. Required: swaps occur only on rises 3, 6, 9; `missed` stays 0.
- **Missed frames:** keep `capture_done` low across 300 eligible rises. Required: `missed` reaches 255 and holds; no swap; `read_index` unchanged.
- **Freeze:** capture complete, `freeze`=1 across 5 rises. Required: state stays READY, no swap. Release `freeze` mid-frame (before the next rise) with `wave_display_idle`=1. Required: swap within 1 cycle. Release `freeze` after a non-eligible rise instead. Required: no swap until the next eligible rise.
- **Blanking gate and same-cycle events:**
  - `wave_display_idle`=0 at the eligible rise and high 40 cycles later. Required: swap occurs at that later cycle.
  - `capture_done` coincident with `elig` and `wave_display_idle`=1. Required: swap one cycle later; `missed` unchanged.
- **Reset and edge suppression:**
  - Assert `reset` during ARMED. Required: `capture_arm`, `swap`, `missed` and `read_index` are 0 immediately, without waiting for a clock edge.
  - Release `reset` with `vsync` high. Required: no `rise` is counted.
